pipe_scoreboard: RTL and testbench



---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_scoreboard_if.sv | 50 +++++
 rtl/pipe_sb_match.sv | 29 ++
 rtl/pipe_scoreboard.sv | 88 ++++++++
 tb/tb_pipe_scoreboard.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard types and forwarding/readiness constants.
// Holds the tracked-stage entry layout, the register-file forwarding select
// and the default result-ready stages used by decode and the forwarding muxes.
package pipe_pkg;
    localparam int FWD_RF         = 0;
    localparam int ALU_READY_DEF  = 1;
    localparam int LOAD_READY_DEF = 2;
    // Entry fields are sized for the largest supported configuration so the
    // type can live here; narrower register/stage numbers are zero-extended.
    localparam int RD_W  = 8;
    localparam int STG_W = 8;
    typedef struct packed {
        logic             valid;
        logic [RD_W-1:0]  rd;
        logic [STG_W-1:0] ready_stage;
    } sb_entry_t;
endpackage

// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: decode <-> scoreboard signal bundle.
// master (decode side): drives id_*, hold, flush; reads stall, fwd_a, fwd_b
// and, with PERF_CNT_EN, the stall_cycles/fwd_events counters.
// slave (scoreboard side): the mirror image.
interface pipe_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 3
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int SEL_W = $clog2(DEPTH + 1);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_rpzero;
    logic             hold;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
`ifdef PERF_CNT_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      fwd_events;
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_rpzero, hold, flush,
        input  stall, fwd_a, fwd_b, stall_cycles, fwd_events
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_rpzero, hold, flush,
        output stall, fwd_a, fwd_b, stall_cycles, fwd_events
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_rpzero, hold, flush,
        input  stall, fwd_a, fwd_b
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_regwrite, id_memread, id_rpzero, hold, flush,
        output stall, fwd_a, fwd_b
    );
`endif
endinterface

// File: rtl/pipe_sb_match.sv
// pipe_sb_match: youngest-match priority encoder and hazard compare for one source.
// ent_i: tracked entries (index 1 = youngest); src_i/used_i: source register
// and whether it is read; fwd_o: 0 = register file, k = stage k;
// hazard_o: the matched entry's result is not ready yet.
module pipe_sb_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  sb_entry_t [DEPTH:1] ent_i,
    input  logic [REG_W-1:0]    src_i,
    input  logic                used_i,
    output logic [SEL_W-1:0]    fwd_o,
    output logic                hazard_o
);
    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_o    = SEL_W'(FWD_RF);
        hazard_o = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used_i && src_i != '0 && ent_i[k].valid && ent_i[k].rd == RD_W'(src_i)) begin
                fwd_o    = SEL_W'(k);
                hazard_o = ent_i[k].ready_stage > STG_W'(k);
            end
        end
    end
endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-flight-write scoreboard giving forwarding selects and load-use stall.
// Ports: clk, rst_async_n (async active-low), sb (pipe_scoreboard_if.slave):
// id_* decode-stage instruction, hold/flush controls, stall and fwd_a/fwd_b
// outputs. Defining PERF_CNT_EN adds saturating stall_cycles/fwd_events counters.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = ALU_READY_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int RSVD_REG   = 30
) (
    input logic                clk,
    input logic                rst_async_n,
    pipe_scoreboard_if.slave   sb
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int SEL_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH:1] ent_q, ent_d;
    sb_entry_t           ent_new;
    logic [SEL_W-1:0]    fwd_a, fwd_b;
    logic                haz_a, haz_b, stall, track;

    pipe_sb_match #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_a (
        .ent_i(ent_q), .src_i(sb.id_rs), .used_i(sb.id_rs_used), .fwd_o(fwd_a), .hazard_o(haz_a)
    );
    pipe_sb_match #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_b (
        .ent_i(ent_q), .src_i(sb.id_rt), .used_i(sb.id_rt_used), .fwd_o(fwd_b), .hazard_o(haz_b)
    );

    assign stall    = sb.id_valid && (haz_a || haz_b);
    assign sb.stall = stall;
    assign sb.fwd_a = fwd_a;
    assign sb.fwd_b = fwd_b;

    // A stalled instruction re-issues next cycle, so it must not be tracked now.
    assign track = sb.id_valid && !stall && sb.id_regwrite && !sb.id_rpzero &&
                   sb.id_rd != '0 && sb.id_rd != REG_W'(RSVD_REG);

    always_comb begin
        ent_new.valid       = track;
        ent_new.rd          = track ? RD_W'(sb.id_rd) : '0;
        ent_new.ready_stage = !track ? '0 : sb.id_memread ? STG_W'(LOAD_READY) : STG_W'(ALU_READY);
    end

    always_comb begin
        ent_d = ent_q;
        if (sb.flush) begin
            ent_d = '0;
        end else if (!sb.hold) begin
            for (int k = DEPTH; k >= 2; k--) ent_d[k] = ent_q[k-1];
            ent_d[1] = ent_new;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) ent_q <= '0;
        else              ent_q <= ent_d;
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, fwd_events_q, fwd_events_d;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_sum        = {1'b0, fwd_events_q} + 33'(fwd_a != '0) + 33'(fwd_b != '0);
        stall_cycles_d = (stall && !sb.hold && !sb.flush && stall_cycles_q != '1) ?
                         stall_cycles_q + 32'd1 : stall_cycles_q;
        fwd_events_d   = !(sb.id_valid && !stall && !sb.hold) ? fwd_events_q :
                         fwd_sum[32] ? '1 : fwd_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign sb.stall_cycles = stall_cycles_q;
    assign sb.fwd_events   = fwd_events_q;
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: table-driven scoreboard bench for pipe_scoreboard (default parameters).
module tb_pipe_scoreboard;
    logic clk = 1'b0;
    logic rst_async_n = 1'b0;

    always #5 clk = ~clk;

    pipe_scoreboard_if #(.NUM_REGS(32), .DEPTH(3)) sb ();

    pipe_scoreboard #(
        .NUM_REGS(32), .DEPTH(3), .ALU_READY(1), .LOAD_READY(2), .RSVD_REG(30)
    ) dut (
        .clk(clk), .rst_async_n(rst_async_n), .sb(sb)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic [4:0] rd;
        logic       rw, mr, rpz, hold, flush;
        logic       es;
        logic [1:0] ea, eb;
    } vec_t;

    typedef struct {
        logic       s;
        logic [1:0] a, b;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   m_stall = 0;
    int   m_fwd = 0;

    function automatic vec_t mk(int v, int rs, int rsu, int rt, int rtu, int rd, int rw, int mr,
                                int rpz, int hold, int flush, int es, int ea, int eb);
        vec_t t;
        t.v = 1'(v); t.rs = 5'(rs); t.rsu = 1'(rsu); t.rt = 5'(rt); t.rtu = 1'(rtu);
        t.rd = 5'(rd); t.rw = 1'(rw); t.mr = 1'(mr); t.rpz = 1'(rpz);
        t.hold = 1'(hold); t.flush = 1'(flush);
        t.es = 1'(es); t.ea = 2'(ea); t.eb = 2'(eb);
        return t;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        sb.id_valid = t.v; sb.id_rs = t.rs; sb.id_rs_used = t.rsu;
        sb.id_rt = t.rt; sb.id_rt_used = t.rtu; sb.id_rd = t.rd;
        sb.id_regwrite = t.rw; sb.id_memread = t.mr; sb.id_rpzero = t.rpz;
        sb.hold = t.hold; sb.flush = t.flush;
        e.s = t.es; e.a = t.ea; e.b = t.eb;
        q.push_back(e);
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        #2;
        if (q.size() == 0) begin
            chk($sformatf("queue_empty[%0d]", idx), 0, 1);
            return;
        end
        e = q.pop_front();
        chk($sformatf("stall[%0d]", idx), int'(sb.stall), int'(e.s));
        chk($sformatf("fwd_a[%0d]", idx), int'(sb.fwd_a), int'(e.a));
        chk($sformatf("fwd_b[%0d]", idx), int'(sb.fwd_b), int'(e.b));
    endtask

    initial begin
        //            v rs su rt tu rd rw mr rz  h  f  es ea eb
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 8, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 30, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 30, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state with live-looking decode inputs.
        apply(mk(1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        check_out(-1);
`ifdef PERF_CNT_EN
        chk("rst_stall_cycles", int'(sb.stall_cycles), 0);
        chk("rst_fwd_events", int'(sb.fwd_events), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_async_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            check_out(i);
            if (tbl[i].es && !tbl[i].hold && !tbl[i].flush) m_stall++;
            if (tbl[i].v && !tbl[i].es && !tbl[i].hold)
                m_fwd += int'(tbl[i].ea != 0) + int'(tbl[i].eb != 0);
        end

        @(negedge clk);
`ifdef PERF_CNT_EN
        chk("stall_cycles", int'(sb.stall_cycles), m_stall);
        chk("fwd_events", int'(sb.fwd_events), m_fwd);
`endif

        // Fill all three stages, then reset between edges.
        apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        check_out(100);
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        check_out(101);
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        check_out(102);
        @(negedge clk);
        apply(mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2));
        check_out(103);
        apply(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 3, 2));
        sb.id_rs = 5'd3;
        q.pop_front();
        #1;
        rst_async_n = 1'b0;
        #1;
        chk("midrst_stall", int'(sb.stall), 0);
        chk("midrst_fwd_a", int'(sb.fwd_a), 0);
        chk("midrst_fwd_b", int'(sb.fwd_b), 0);
`ifdef PERF_CNT_EN
        chk("midrst_stall_cycles", int'(sb.stall_cycles), 0);
        chk("midrst_fwd_events", int'(sb.fwd_events), 0);
`endif
        rst_async_n = 1'b1;
        @(negedge clk);
        apply(mk(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_out(104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
